uart_txrx_top: RTL and testbench

Full-duplex 8N1 UART block with one transmitter and one receiver sharing a single system clock. It serializes a parallel byte onto `tx` and deserializes the `rx` line into a parallel byte, with done, busy and error status for each direction. It sits between the system bus logic and the board-level serial pins.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_txrx_if.sv | 23 ++
 rtl/uart_rx.sv | 65 ++++++
 rtl/uart_tx.sv | 50 +++++
 rtl/uart_txrx_top.sv | 33 +++
 tb/tb_uart_txrx_top.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, bit-period helper and FSM state type for the UART slice.
package uart_pkg;
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD = 57_600;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_txrx_if.sv
// uart_txrx_if: parallel-side and pin-side signals of the full-duplex UART.
interface uart_txrx_if;
    logic txEnable;
    logic txStart;
    logic [7:0] in;
    logic tx;
    logic txDone;
    logic txBusy;
    logic rxEnable;
    logic rx;
    logic [7:0] out;
    logic rxDone;
    logic rxError;
    logic rxBusy;
    modport master (
        output txEnable, txStart, in, rxEnable, rx,
        input tx, txDone, txBusy, out, rxDone, rxError, rxBusy
    );
    modport slave (
        input txEnable, txStart, in, rxEnable, rx,
        output tx, txDone, txBusy, out, rxDone, rxError, rxBusy
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 deserializer with 2-flop input synchronizer, mid-bit sampling
// and false-start rejection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] data,
    output logic       done,
    output logic       error,
    output logic       busy
);
    localparam int CW = $clog2(CPB);
    state_t state, nxt;
    logic [1:0] sync;
    logic line;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic tick;
    logic half;
    logic stop_smp;
    assign line = sync[1];
    always_comb begin
        tick = cnt == CW'(CPB - 1);
        half = cnt == CW'(CPB / 2 - 1);
        nxt = state;
        case (state)
            IDLE:    nxt = !line ? START : IDLE;
            START:   nxt = half ? (line ? IDLE : DATA) : START;
            DATA:    nxt = tick && idx == 3'd7 ? STOP : DATA;
            STOP:    nxt = tick ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
        if (!enable) nxt = IDLE;
    end
    // a disabled receiver must not report the stop sample it was about to take
    assign stop_smp = state == STOP && tick && enable;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            data <= '0;
            done <= 1'b0;
            error <= 1'b0;
        end else begin
            sync <= {sync[0], rx};
            state <= nxt;
            cnt <= state == IDLE || nxt != state || tick ? '0 : cnt + 1'b1;
            idx <= state != DATA ? '0 : tick ? idx + 1'b1 : idx;
            shreg <= state == DATA && tick ? {line, shreg[7:1]} : shreg;
            data <= stop_smp && line ? shreg : data;
            done <= stop_smp && line;
            error <= stop_smp && !line;
        end
    end
    assign busy = state != IDLE;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer; the byte is captured when a frame starts.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CPB = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       busy
);
    localparam int CW = $clog2(CPB);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic tick;
    always_comb begin
        tick = cnt == CW'(CPB - 1);
        nxt = state;
        case (state)
            IDLE:    nxt = enable && start ? START : IDLE;
            START:   nxt = tick ? DATA : START;
            DATA:    nxt = tick && idx == 3'd7 ? STOP : DATA;
            STOP:    nxt = tick ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
            shreg <= '0;
            done <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
            idx <= state != DATA ? '0 : tick ? idx + 1'b1 : idx;
            shreg <= state == IDLE && nxt == START ? data : shreg;
            done <= state == STOP && tick;
        end
    end
    assign busy = state != IDLE;
    assign tx = state == START ? 1'b0 : state == DATA ? shreg[idx] : 1'b1;
endmodule

// File: rtl/uart_txrx_top.sv
// uart_txrx_top: full-duplex 8N1 UART; independent TX and RX sharing one clock.
module uart_txrx_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD = DEF_BAUD
) (
    input logic clk,
    input logic rst_n,
    uart_txrx_if.slave bus
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    uart_tx #(.CPB(CLKS_PER_BIT)) u_tx (
        .clk(clk),
        .rst_n(rst_n),
        .enable(bus.txEnable),
        .start(bus.txStart),
        .data(bus.in),
        .tx(bus.tx),
        .done(bus.txDone),
        .busy(bus.txBusy)
    );
    uart_rx #(.CPB(CLKS_PER_BIT)) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .enable(bus.rxEnable),
        .rx(bus.rx),
        .data(bus.out),
        .done(bus.rxDone),
        .error(bus.rxError),
        .busy(bus.rxBusy)
    );
endmodule

// File: tb/tb_uart_txrx_top.sv
// tb_uart_txrx_top: directed stimulus with a frame-level timing model checked every cycle.
module tb_uart_txrx_top;
    localparam int CPB = 868;
    localparam int HALF = CPB / 2;
    localparam int FRAME = 10 * CPB;
    logic clk = 1'b0;
    logic rst_n;
    uart_txrx_if bus();
    uart_txrx_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #10 clk = ~clk;

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    bit hist [0:65535];
    bit t_act = 0;
    int t_s = 0;
    logic [7:0] t_b = '0;
    bit r_act = 0;
    int r_d = 0;
    int rd_at = -1;
    int re_at = -1;
    logic [7:0] m_out = '0;
    int td_n = 0;
    int tb_n = 0;
    int rd_n = 0;
    int re_n = 0;
    int rise_q[$];
    int last_rise = 0;
    logic [9:0] cap = '0;
    logic pbusy = 1'b0;

    // Frame-level model: TX frames are timed from the accepting edge, RX frames
    // from the edge where the synchronized line (rx two edges earlier) is first low.
    always @(posedge clk) begin
        logic l;
        int k;
        logic [7:0] b;
        cyc = cyc + 1;
        if (!rst_n) begin
            hist[cyc] = 1'b1;
            t_act = 0;
            r_act = 0;
            m_out = '0;
            rd_at = -1;
            re_at = -1;
        end else begin
            hist[cyc] = bus.rx;
            if ((!t_act || cyc >= t_s + FRAME + 1) && bus.txEnable && bus.txStart) begin
                t_act = 1;
                t_s = cyc;
                t_b = bus.in;
            end
            l = hist[cyc-2];
            if (r_act) begin
                k = cyc - r_d;
                if (!bus.rxEnable) r_act = 0;
                else if (k == HALF && l) r_act = 0;
                else if (k == HALF + 9 * CPB) begin
                    for (int j = 0; j < 8; j++) b[j] = hist[r_d + HALF + CPB * (j + 1) - 2];
                    if (l) begin
                        m_out = b;
                        rd_at = cyc;
                    end else re_at = cyc;
                    r_act = 0;
                end
            end else if (bus.rxEnable && !l) begin
                r_act = 1;
                r_d = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            int k;
            int j;
            logic e_tx, e_tb, e_td, e_rb, e_rd, e_re;
            logic [7:0] e_o;
            @(negedge clk);
            k = cyc - t_s;
            j = k / CPB;
            e_tb = rst_n && t_act && k < FRAME;
            e_td = rst_n && t_act && k == FRAME;
            e_tx = !e_tb ? 1'b1 : j == 0 ? 1'b0 : j == 9 ? 1'b1 : t_b[j-1];
            e_rb = rst_n && r_act;
            e_rd = rst_n && cyc == rd_at;
            e_re = rst_n && cyc == re_at;
            e_o = rst_n ? m_out : 8'h00;
            chk("tx", bus.tx, e_tx);
            chk("txBusy", bus.txBusy, e_tb);
            chk("txDone", bus.txDone, e_td);
            chk("rxBusy", bus.rxBusy, e_rb);
            chk("rxDone", bus.rxDone, e_rd);
            chk("rxError", bus.rxError, e_re);
            chk("out", bus.out, e_o);
            if (bus.txDone) td_n++;
            if (bus.txBusy) tb_n++;
            if (bus.rxDone) rd_n++;
            if (bus.rxError) re_n++;
            if (bus.txBusy && !pbusy) begin
                rise_q.push_back(cyc);
                last_rise = cyc;
            end
            pbusy = bus.txBusy;
            if (bus.txBusy && (cyc - last_rise) % CPB == HALF && (cyc - last_rise) / CPB < 10)
                cap[(cyc - last_rise) / CPB] = bus.tx;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            wait_cyc(CPB);
        end
        bus.rx = 1'b1;
    endtask

    initial begin
        int td0, tb0, rd0, re0, nr;
        rst_n = 1'b0;
        bus.txEnable = 1'b0;
        bus.txStart = 1'b0;
        bus.in = 8'h00;
        bus.rxEnable = 1'b1;
        bus.rx = 1'b0;
        fork
            monitor();
        join_none
        wait_cyc(3);
        chk("rst tx", bus.tx, 1);
        chk("rst txBusy", bus.txBusy, 0);
        chk("rst txDone", bus.txDone, 0);
        chk("rst rxBusy", bus.rxBusy, 0);
        chk("rst rxDone", bus.rxDone, 0);
        chk("rst rxError", bus.rxError, 0);
        chk("rst out", bus.out, 8'h00);

        // single TX frame of 0x8F alongside an RX frame of 0x8B starting at reset release
        td0 = td_n; tb0 = tb_n; rd0 = rd_n; re0 = re_n;
        rst_n = 1'b1;
        bus.txEnable = 1'b1;
        fork
            begin
                bus.in = 8'h8F;
                bus.txStart = 1'b1;
                wait_cyc(1);
                bus.txStart = 1'b0;
                bus.in = 8'h00;
            end
            rx_frame(8'h8B, 1'b1);
        join
        wait_cyc(400);
        chk("tx bits 0x8F", cap, 10'h31E);
        chk("txDone pulses", td_n - td0, 1);
        chk("txBusy cycles", tb_n - tb0, 8680);
        chk("rx good out", bus.out, 8'h8B);
        chk("rxDone pulses", rd_n - rd0, 1);
        chk("rxError pulses", re_n - re0, 0);

        // continuous TX with txEnable dropped mid third frame; RX error, glitch, disable
        td0 = td_n; rd0 = rd_n; re0 = re_n;
        nr = rise_q.size();
        bus.in = 8'h8F;
        bus.txStart = 1'b1;
        fork
            begin
                wait_cyc(2 * (FRAME + 1) + 100);
                bus.txEnable = 1'b0;
                wait_cyc(FRAME + 200);
                bus.txStart = 1'b0;
                bus.txEnable = 1'b1;
            end
            begin
                rx_frame(8'h8B, 1'b0);
                wait_cyc(900);
                chk("ferr rxError pulses", re_n - re0, 1);
                chk("ferr rxDone pulses", rd_n - rd0, 0);
                chk("ferr out kept", bus.out, 8'h8B);
                bus.rx = 1'b0;
                wait_cyc(10);
                bus.rx = 1'b1;
                wait_cyc(600);
                chk("glitch rxBusy", bus.rxBusy, 0);
                chk("glitch flags", (rd_n - rd0) + (re_n - re0), 1);
                bus.rx = 1'b0;
                wait_cyc(2000);
                chk("frame rxBusy", bus.rxBusy, 1);
                bus.rxEnable = 1'b0;
                wait_cyc(2);
                chk("disable rxBusy", bus.rxBusy, 0);
                bus.rx = 1'b1;
                wait_cyc(5);
                bus.rxEnable = 1'b1;
                wait_cyc(20);
                chk("disable flags", (rd_n - rd0) + (re_n - re0), 1);
                chk("disable out kept", bus.out, 8'h8B);
            end
        join
        chk("cont frames", rise_q.size() - nr, 3);
        if (rise_q.size() - nr == 3) begin
            chk("cont gap 1", rise_q[nr+1] - rise_q[nr], 8681);
            chk("cont gap 2", rise_q[nr+2] - rise_q[nr+1], 8681);
        end
        chk("cont txDone pulses", td_n - td0, 3);
        chk("cont tx bits 0x8F", cap, 10'h31E);

        // reset mid-frame in both directions
        bus.in = 8'h55;
        bus.txStart = 1'b1;
        bus.rx = 1'b0;
        wait_cyc(1);
        bus.txStart = 1'b0;
        wait_cyc(2000);
        chk("pre-rst txBusy", bus.txBusy, 1);
        chk("pre-rst rxBusy", bus.rxBusy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid-rst tx", bus.tx, 1);
        chk("mid-rst txBusy", bus.txBusy, 0);
        chk("mid-rst rxBusy", bus.rxBusy, 0);
        chk("mid-rst out", bus.out, 8'h00);
        wait_cyc(3);
        bus.rx = 1'b1;
        rst_n = 1'b1;
        wait_cyc(50);
        chk("post-rst txBusy", bus.txBusy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
